// File: rtl/cfg_pkg.sv
// cfg_pkg: shared op, status and FSM encodings for the configuration shadow register file.
package cfg_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_COMMIT, OP_DISCARD} op_e;
  typedef enum logic [2:0] {ST_OK, ST_ERR_ADDR, ST_ERR_RANGE, ST_ERR_TIMEOUT, ST_ERR_LOCKED} status_e;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT_APPLY, S_RESP} state_e;
endpackage

// File: rtl/cfg_range_check.sv
// cfg_range_check: slot address validity and signed inclusive bound check for a write value.
module cfg_range_check
  import cfg_pkg::*;
#(
  parameter int NUM_PARAMS = 8,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [NUM_PARAMS*DATA_W-1:0] PARAM_MIN_FLAT = {NUM_PARAMS{8'h80}},
  parameter logic [NUM_PARAMS*DATA_W-1:0] PARAM_MAX_FLAT = {NUM_PARAMS{8'h7F}}
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              addr_ok_o,
  output logic              range_ok_o
);
  logic signed [DATA_W-1:0] lo, hi;
  always_comb begin
    lo = '0;
    hi = '0;
    for (int i = 0; i < NUM_PARAMS; i++)
      if (addr_i == ADDR_W'(i)) begin
        lo = PARAM_MIN_FLAT[i*DATA_W +: DATA_W];
        hi = PARAM_MAX_FLAT[i*DATA_W +: DATA_W];
      end
  end
  assign addr_ok_o  = 32'(addr_i) < 32'(NUM_PARAMS);
  assign range_ok_o = $signed(wdata_i) >= lo && $signed(wdata_i) <= hi;
endmodule

// File: rtl/cfg_shadow_regfile.sv
// cfg_shadow_regfile: ranged parameter store; writes go to a shadow bank, COMMIT copies it to the active bank while idle.
// Define CFG_LOCK_EN to add lock_in, which rejects WRITE/COMMIT/DISCARD with ERR_LOCKED.
module cfg_shadow_regfile
  import cfg_pkg::*;
#(
  parameter int NUM_PARAMS = 8,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [NUM_PARAMS*DATA_W-1:0] PARAM_MIN_FLAT = {NUM_PARAMS{8'h80}},
  parameter logic [NUM_PARAMS*DATA_W-1:0] PARAM_MAX_FLAT = {NUM_PARAMS{8'h7F}},
  parameter logic [NUM_PARAMS*DATA_W-1:0] PARAM_DEF_FLAT = {NUM_PARAMS{8'h00}},
  parameter int APPLY_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef CFG_LOCK_EN
  input  logic                         lock_in,
`endif
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  input  logic                         apply_allowed,
  output logic                         rsp_valid,
  output logic [2:0]                   rsp_status,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [NUM_PARAMS*DATA_W-1:0] param_flat,
  output logic                         param_update,
  output logic                         pending
);
  localparam int CNT_W = APPLY_TIMEOUT > 1 ? $clog2(APPLY_TIMEOUT) : 1;
  localparam int FW = NUM_PARAMS * DATA_W;
  state_e state_q, state_d;
  op_e op_q, op_d;
  status_e status_q, status_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0] active_q, active_d, shadow_q, shadow_d;
  logic [NUM_PARAMS-1:0] dirty_q, dirty_d;
  logic rsp_valid_q, rsp_valid_d, upd_q, upd_d;
  logic addr_ok, range_ok, locked;
`ifdef CFG_LOCK_EN
  assign locked = lock_in;
`else
  assign locked = 1'b0;
`endif
  cfg_range_check #(
    .NUM_PARAMS(NUM_PARAMS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .PARAM_MIN_FLAT(PARAM_MIN_FLAT), .PARAM_MAX_FLAT(PARAM_MAX_FLAT)
  ) u_range (
    .addr_i(addr_q), .wdata_i(wdata_q), .addr_ok_o(addr_ok), .range_ok_o(range_ok)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    active_d = active_q;
    shadow_d = shadow_q;
    dirty_d = dirty_q;
    status_d = ST_OK;
    rdata_d = '0;
    rsp_valid_d = 1'b0;
    upd_d = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        op_d = op_e'(cmd_op);
        addr_d = cmd_addr;
        wdata_d = cmd_wdata;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_RESP;
        rsp_valid_d = 1'b1;
        if (locked && op_q != OP_READ) status_d = ST_ERR_LOCKED;
        else case (op_q)
          OP_WRITE: begin
            status_d = !addr_ok ? ST_ERR_ADDR : !range_ok ? ST_ERR_RANGE : ST_OK;
            for (int i = 0; i < NUM_PARAMS; i++)
              if (addr_ok && range_ok && addr_q == ADDR_W'(i)) begin
                shadow_d[i*DATA_W +: DATA_W] = wdata_q;
                dirty_d[i] = 1'b1;
              end
          end
          OP_READ: begin
            status_d = addr_ok ? ST_OK : ST_ERR_ADDR;
            for (int i = 0; i < NUM_PARAMS; i++)
              if (addr_q == ADDR_W'(i)) rdata_d = shadow_q[i*DATA_W +: DATA_W];
          end
          OP_DISCARD: begin
            shadow_d = active_q;
            dirty_d = '0;
          end
          default: if (|dirty_q) begin
            state_d = S_WAIT_APPLY;
            rsp_valid_d = 1'b0;
            cnt_d = '0;
          end
        endcase
      end
      S_WAIT_APPLY:
        if (apply_allowed) begin
          active_d = shadow_q;
          dirty_d = '0;
          upd_d = 1'b1;
          rsp_valid_d = 1'b1;
          state_d = S_RESP;
        end else if (APPLY_TIMEOUT != 0 && cnt_q == CNT_W'(APPLY_TIMEOUT - 1)) begin
          status_d = ST_ERR_TIMEOUT;
          rsp_valid_d = 1'b1;
          state_d = S_RESP;
        end else cnt_d = cnt_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= OP_WRITE;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      active_q <= PARAM_DEF_FLAT;
      shadow_q <= PARAM_DEF_FLAT;
      dirty_q <= '0;
      status_q <= ST_OK;
      rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      dirty_q <= dirty_d;
      status_q <= status_d;
      rdata_q <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      upd_q <= upd_d;
    end
  assign cmd_ready = state_q == S_IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_status = status_q;
  assign rsp_rdata = rdata_q;
  assign param_flat = active_q;
  assign param_update = upd_q;
  assign pending = |dirty_q;
endmodule

// File: tb/tb_cfg_shadow_regfile.sv
// tb_cfg_shadow_regfile: directed and random commands against an array-based model of the shadow/active banks.
module tb_cfg_shadow_regfile;
  localparam int NP = 5;
  localparam int TO = 16;
  localparam logic [39:0] MINF = {8'hCE, 8'hF6, 8'h00, 8'hFD, 8'h80};
  localparam logic [39:0] MAXF = {8'h32, 8'h0A, 8'h64, 8'h14, 8'h7F};
  localparam logic [39:0] DEFF = {8'h10, 8'h00, 8'h00, 8'h00, 8'h05};
  logic clk = 0, rst_n = 0, cmd_valid = 0, apply_allowed = 0, lock = 0;
  logic [1:0] cmd_op = 0;
  logic [2:0] cmd_addr = 0;
  logic [7:0] cmd_wdata = 0;
  logic cmd_ready, rsp_valid, param_update, pending;
  logic [2:0] rsp_status;
  logic [7:0] rsp_rdata;
  logic [39:0] param_flat;
  int total = 0, bad = 0;
  int mn[NP] = '{-128, -3, 0, -10, -50};
  int mx[NP] = '{127, 20, 100, 10, 50};
  int df[NP] = '{5, 0, 0, 0, 16};
  int act[NP], shd[NP];
  bit dirty[NP];
  always #5 clk = ~clk;
  cfg_shadow_regfile #(
    .NUM_PARAMS(NP), .DATA_W(8), .ADDR_W(3),
    .PARAM_MIN_FLAT(MINF), .PARAM_MAX_FLAT(MAXF), .PARAM_DEF_FLAT(DEFF),
    .APPLY_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef CFG_LOCK_EN
    .lock_in(lock),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .apply_allowed(apply_allowed),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .param_flat(param_flat), .param_update(param_update), .pending(pending)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [39:0] act_flat();
    logic [39:0] r;
    for (int i = 0; i < NP; i++) r[i*8 +: 8] = 8'(act[i]);
    return r;
  endfunction
  function automatic logic any_dirty();
    logic r = 0;
    for (int i = 0; i < NP; i++) r |= dirty[i];
    return r;
  endfunction
  task automatic reset_model();
    for (int i = 0; i < NP; i++) begin
      act[i] = df[i];
      shd[i] = df[i];
      dirty[i] = 0;
    end
  endtask
  // hold = wait cycles with apply_allowed low before it rises; negative keeps it low
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] a, input logic [7:0] w, input int hold);
    int es = 0, el = 2, sv, lat = 0, nupd = 0;
    logic [7:0] er = 0, got_rd = 0;
    logic eu = 0, got_upd = 0;
    logic [2:0] got_st = 0;
    sv = $signed(w);
    if (lock && op != 2'd1) es = 4;
    else case (op)
      2'd0: if (a >= NP) es = 1;
            else if (sv < mn[a] || sv > mx[a]) es = 2;
            else begin shd[a] = sv; dirty[a] = 1; end
      2'd1: if (a >= NP) es = 1; else er = 8'(shd[a]);
      2'd3: for (int i = 0; i < NP; i++) begin shd[i] = act[i]; dirty[i] = 0; end
      default: if (any_dirty()) begin
        if (hold >= 0 && hold < TO) begin
          el = 3 + hold;
          eu = 1;
          for (int i = 0; i < NP; i++) begin act[i] = shd[i]; dirty[i] = 0; end
        end else begin
          es = 3;
          el = 2 + TO;
        end
      end
    endcase
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_wdata = w; apply_allowed = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      cmd_valid = 0;
      apply_allowed = hold >= 0 && k >= 2 + hold;
      if (param_update) nupd++;
      if (rsp_valid) begin
        lat = k; got_st = rsp_status; got_rd = rsp_rdata; got_upd = param_update;
        break;
      end
    end
    apply_allowed = 0;
    check("latency", 64'(lat), 64'(el));
    check("status", 64'(got_st), 64'(es));
    check("rdata", 64'(got_rd), 64'(er));
    check("update_at_rsp", 64'(got_upd), 64'(eu));
    check("update_count", 64'(nupd), 64'(eu));
    @(negedge clk);
    check("ready_after", 64'(cmd_ready), 64'd1);
    check("rsp_single_pulse", 64'(rsp_valid), 64'd0);
    check("param_flat", 64'(param_flat), 64'(act_flat()));
    check("pending", 64'(pending), 64'(any_dirty()));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int seen, r;
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_update", 64'(param_update), 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 1);
    check("rst_status", 64'(rsp_status), 0);
    check("rst_rdata", 64'(rsp_rdata), 0);
    check("rst_pending", 64'(pending), 0);
    check("rst_flat", 64'(param_flat), 64'(DEFF));
    do_cmd(2'd1, 3'd2, 8'h00, 0);
    do_cmd(2'd0, 3'd1, 8'hFC, 0);
    do_cmd(2'd0, 3'd1, 8'h14, 0);
    do_cmd(2'd0, 3'd1, 8'h15, 0);
    do_cmd(2'd1, 3'd1, 8'h00, 0);
    do_cmd(2'd0, 3'd3, 8'hFB, 0);
    do_cmd(2'd2, 3'd0, 8'h00, 10);
    do_cmd(2'd1, 3'd3, 8'h00, 0);
    do_cmd(2'd2, 3'd0, 8'h00, 0);
    do_cmd(2'd0, 3'd0, 8'h07, 0);
    do_cmd(2'd2, 3'd0, 8'h00, -1);
    do_cmd(2'd3, 3'd0, 8'h00, 0);
    do_cmd(2'd0, 3'd6, 8'h01, 0);
    do_cmd(2'd1, 3'd7, 8'h00, 0);
    do_cmd(2'd0, 3'd1, 8'hFD, 0);
    do_cmd(2'd2, 3'd0, 8'h00, 0);
    do_cmd(2'd0, 3'd2, 8'h00, 0);
    do_cmd(2'd2, 3'd0, 8'h00, 15);
    do_cmd(2'd0, 3'd4, 8'hCE, 0);
    do_cmd(2'd2, 3'd0, 8'h00, 16);
    do_cmd(2'd3, 3'd0, 8'h00, 0);
`ifdef CFG_LOCK_EN
    lock = 1;
    do_cmd(2'd0, 3'd2, 8'h05, 0);
    do_cmd(2'd1, 3'd2, 8'h00, 0);
    do_cmd(2'd3, 3'd0, 8'h00, 0);
    lock = 0;
    do_cmd(2'd0, 3'd2, 8'h05, 0);
`endif
    do_cmd(2'd0, 3'd4, 8'hF9, 0);
    @(negedge clk);
    cmd_valid = 1; cmd_op = 2'd2; apply_allowed = 0;
    @(negedge clk);
    cmd_valid = 0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen++; end
    #2 rst_n = 0;
    reset_model();
    @(negedge clk);
    if (rsp_valid) seen++;
    check("midrst_ready", 64'(cmd_ready), 1);
    check("midrst_pending", 64'(pending), 0);
    check("midrst_flat", 64'(param_flat), 64'(DEFF));
    rst_n = 1;
    repeat (4) begin @(negedge clk); if (rsp_valid) seen++; end
    check("midrst_no_rsp", 64'(seen), 0);
    check("midrst_ready_after", 64'(cmd_ready), 1);
    do_cmd(2'd1, 3'd4, 8'h00, 0);
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      do_cmd(r < 4 ? 2'd0 : r < 6 ? 2'd1 : r < 8 ? 2'd2 : 2'd3,
             3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 20));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
